// File: rtl/acc_cpu.sv
// Accumulator CPU: FETCH/EXEC per instruction (2 cycles), HALT until reset; no backpressure, memory is zero-wait.
// Define ACC_CPU_SCAN_EN to compile in the scan shadow chain that freezes the core while scan_en is high.
module acc_cpu #(
    parameter int W   = 4,
    parameter int OPW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_en,
    output logic             scan_out,
    output logic             we,
    output logic [W-1:0]     addr,
    input  logic [W+OPW-1:0] data_in,
    output logic [W-1:0]     data_out,
    output logic             halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [OPW-1:0] OP_LDA  = 4'h1;
    localparam logic [OPW-1:0] OP_LDAI = 4'h2;
    localparam logic [OPW-1:0] OP_STA  = 4'h3;
    localparam logic [OPW-1:0] OP_ADD  = 4'h4;
    localparam logic [OPW-1:0] OP_ADDI = 4'h5;
    localparam logic [OPW-1:0] OP_SUB  = 4'h6;
    localparam logic [OPW-1:0] OP_SUBI = 4'h7;
    localparam logic [OPW-1:0] OP_JMP  = 4'h8;
    localparam logic [OPW-1:0] OP_BRZ  = 4'h9;
    localparam logic [OPW-1:0] OP_BRC  = 4'hA;
    localparam logic [OPW-1:0] OP_BRN  = 4'hB;
    localparam logic [OPW-1:0] OP_HLT  = 4'hF;

    state_t         state, state_n;
    logic [W-1:0]   pc, pc_n, acc, acc_n, dr, dr_n;
    logic [OPW-1:0] ir, ir_n;
    logic           c_flag, c_n, z_flag, z_n, n_flag, n_n;
    logic           frozen, upd_zn, indirect;
    logic [W-1:0]   operand;
    logic [W:0]     sum, diff;

    assign indirect = (ir == OP_LDAI) || (ir == OP_ADDI) || (ir == OP_SUBI);
    assign operand  = indirect ? data_in[W+OPW-1:OPW] : dr;
    assign sum      = {1'b0, acc} + {1'b0, operand};
    // Top bit of the widened difference is the borrow out.
    assign diff     = {1'b0, acc} - {1'b0, operand};

    assign data_out = acc;
    assign halted   = (state == S_HALT);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        acc_n   = acc;
        dr_n    = dr;
        ir_n    = ir;
        c_n     = c_flag;
        z_n     = z_flag;
        n_n     = n_flag;
        upd_zn  = 1'b0;
        we      = 1'b0;
        addr    = pc;
        case (state)
            S_FETCH: begin
                ir_n    = data_in[OPW-1:0];
                dr_n    = data_in[W+OPW-1:OPW];
                state_n = S_EXEC;
            end
            S_EXEC: begin
                addr    = dr;
                state_n = S_FETCH;
                pc_n    = pc + 1'b1;
                case (ir)
                    OP_LDA, OP_LDAI: begin
                        acc_n  = operand;
                        c_n    = 1'b0;
                        upd_zn = 1'b1;
                    end
                    OP_STA: we = 1'b1;
                    OP_ADD, OP_ADDI: begin
                        {c_n, acc_n} = sum;
                        upd_zn       = 1'b1;
                    end
                    OP_SUB, OP_SUBI: begin
                        acc_n  = diff[W-1:0];
                        c_n    = diff[W];
                        upd_zn = 1'b1;
                    end
                    OP_JMP: pc_n = dr;
                    OP_BRZ: if (z_flag) pc_n = pc + dr;
                    OP_BRC: if (c_flag) pc_n = pc + dr;
                    OP_BRN: if (n_flag) pc_n = pc + dr;
                    OP_HLT: begin
                        pc_n    = pc;
                        state_n = S_HALT;
                    end
                    default: ;
                endcase
                if (upd_zn) begin
                    z_n = (acc_n == '0);
                    n_n = acc_n[W-1];
                end
            end
            default: ;
        endcase
        if (frozen) we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_FETCH;
            pc     <= '0;
            acc    <= '0;
            dr     <= '0;
            ir     <= '0;
            c_flag <= 1'b0;
            z_flag <= 1'b0;
            n_flag <= 1'b0;
        end else if (!frozen) begin
            state  <= state_n;
            pc     <= pc_n;
            acc    <= acc_n;
            dr     <= dr_n;
            ir     <= ir_n;
            c_flag <= c_n;
            z_flag <= z_n;
            n_flag <= n_n;
        end
    end

`ifdef ACC_CPU_SCAN_EN
    localparam int L = OPW + 3*W + 5;
    logic [L-1:0] shadow;
    logic         scan_q;

    assign frozen   = scan_en;
    assign scan_out = shadow[L-1];

    // Each rising scan_en takes a fresh snapshot; zeros fill in behind the shifted bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            scan_q <= 1'b0;
        end else begin
            scan_q <= scan_en;
            if (scan_en && !scan_q)
                shadow <= {ir, dr, acc, c_flag, z_flag, n_flag, pc, state};
            else if (scan_en)
                shadow <= {shadow[L-2:0], 1'b0};
        end
    end
`else
    logic unused_scan_en;
    assign unused_scan_en = scan_en;
    assign frozen         = 1'b0;
    assign scan_out       = 1'b0;
`endif

endmodule

// File: tb/tb_acc_cpu.sv
// Bench for acc_cpu: directed vector table, hand sequences and random programs against an instruction-level model.
module tb_acc_cpu;

    logic        clk = 1'b0;
    logic        rst4 = 1'b1, rst8 = 1'b1, scan_en = 1'b0;
    logic        scan_out4, we4, halted4, scan_out8, we8, halted8;
    logic [3:0]  addr4, dout4;
    logic [7:0]  addr8, dout8;
    logic [7:0]  din4;
    logic [11:0] din8;
    logic [7:0]  mem4 [16];
    logic [11:0] mem8 [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acc_cpu #(.W(4), .OPW(4)) u4 (
        .clk(clk), .rst(rst4), .scan_en(scan_en), .scan_out(scan_out4), .we(we4),
        .addr(addr4), .data_in(din4), .data_out(dout4), .halted(halted4)
    );
    acc_cpu #(.W(8), .OPW(4)) u8 (
        .clk(clk), .rst(rst8), .scan_en(scan_en), .scan_out(scan_out8), .we(we8),
        .addr(addr8), .data_in(din8), .data_out(dout8), .halted(halted8)
    );

    assign din4 = mem4[addr4];
    assign din8 = mem8[addr8];
    always @(posedge clk) begin
        if (we4) mem4[addr4] <= {dout4, 4'h0};
        if (we8) mem8[addr8] <= {dout8, 4'h0};
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset4();
        rst4 = 1'b1;
        tick(1);
        rst4 = 1'b0;
    endtask

    task automatic reset8();
        rst8 = 1'b1;
        tick(1);
        rst8 = 1'b0;
    endtask

    task automatic clear4();
        for (int i = 0; i < 16; i++) mem4[i] = 8'h00;
    endtask

    // Instruction-level reference model for the W=4 core.
    int m_pc, m_acc, m_c, m_z, m_n, m_halt;
    int mm [16];

    task automatic model_step(output int ew);
        int op, d, opnd, s;
        ew = 0;
        if (m_halt != 0) return;
        op   = mm[m_pc] % 16;
        d    = mm[m_pc] / 16;
        opnd = (op == 2 || op == 5 || op == 7) ? mm[d] / 16 : d;
        case (op)
            1, 2: begin m_acc = opnd; m_c = 0; end
            3: begin ew = 1; mm[d] = m_acc * 16; end
            4, 5: begin s = m_acc + opnd; m_c = (s > 15) ? 1 : 0; m_acc = s % 16; end
            6, 7: begin m_c = (m_acc < opnd) ? 1 : 0; m_acc = (m_acc - opnd + 16) % 16; end
            default: ;
        endcase
        if (op == 1 || op == 2 || (op >= 4 && op <= 7)) begin
            m_z = (m_acc == 0) ? 1 : 0;
            m_n = (m_acc >= 8) ? 1 : 0;
        end
        if (op == 8) m_pc = d;
        else if ((op == 9 && m_z != 0) || (op == 10 && m_c != 0) || (op == 11 && m_n != 0))
            m_pc = (m_pc + d) % 16;
        else if (op == 15) m_halt = 1;
        else m_pc = (m_pc + 1) % 16;
    endtask

    // LDA a ; <op> b ; <br> 4  -> acc after op, and whether the branch at pc=2 lands on 6 (else 3)
    typedef struct {
        int a; int op; int b; int br; int ind; int exp_acc; int exp_tk;
    } vec_t;
    vec_t vt [16];

    initial begin
        int ew, nwe;
        logic [20:0] snap;

        vt[0]  = '{5, 1, 7, 9, 0, 7, 0};
        vt[1]  = '{5, 1, 0, 9, 0, 0, 1};
        vt[2]  = '{5, 4, 12, 10, 0, 1, 1};
        vt[3]  = '{3, 4, 4, 10, 0, 7, 0};
        vt[4]  = '{3, 6, 5, 11, 0, 14, 1};
        vt[5]  = '{3, 6, 5, 10, 0, 14, 1};
        vt[6]  = '{3, 6, 5, 9, 0, 14, 0};
        vt[7]  = '{5, 6, 5, 9, 0, 0, 1};
        vt[8]  = '{5, 6, 5, 10, 0, 0, 0};
        vt[9]  = '{7, 6, 2, 11, 0, 5, 0};
        vt[10] = '{8, 4, 8, 9, 0, 0, 1};
        vt[11] = '{8, 4, 8, 10, 0, 0, 1};
        vt[12] = '{9, 12, 5, 11, 0, 9, 1};
        vt[13] = '{0, 2, 14, 11, 13, 13, 1};
        vt[14] = '{1, 5, 14, 10, 15, 0, 1};
        vt[15] = '{2, 7, 14, 10, 3, 15, 1};

        clear4();
        for (int i = 0; i < 256; i++) mem8[i] = 12'h000;
        tick(1);
        reset4();
        reset8();
        check("rst_addr", addr4, 0);
        check("rst_we", we4, 0);
        check("rst_data_out", dout4, 0);
        check("rst_halted", halted4, 0);
        check("rst_scan_out", scan_out4, 0);
        check("rst_addr_w8", addr8, 0);

        for (int i = 0; i < 16; i++) begin
            clear4();
            mem4[0]  = 8'(vt[i].a * 16 + 1);
            mem4[1]  = 8'(vt[i].b * 16 + vt[i].op);
            mem4[2]  = 8'(4 * 16 + vt[i].br);
            mem4[14] = 8'(vt[i].ind * 16);
            reset4();
            tick(4);
            check($sformatf("vec%0d_acc", i), dout4, vt[i].exp_acc);
            tick(2);
            check($sformatf("vec%0d_pc", i), addr4, (vt[i].exp_tk != 0) ? 6 : 3);
        end

        // LDA 5, ADD 0xC, HLT
        clear4();
        mem4[0] = 8'h51; mem4[1] = 8'hC4; mem4[2] = 8'h0F;
        reset4();
        tick(6);
        check("hlt_acc", dout4, 1);
        check("hlt_halted", halted4, 1);
        check("hlt_pc", addr4, 2);
        tick(4);
        check("hlt_hold_halted", halted4, 1);
        check("hlt_hold_pc", addr4, 2);
        check("hlt_hold_we", we4, 0);
        rst4 = 1'b1;
        tick(1);
        rst4 = 1'b0;
        check("hlt_rst_halted", halted4, 0);
        check("hlt_rst_acc", dout4, 0);

        // LDA 3, SUB 5, JMP 4, BRN 3 at pc=4 -> pc=7
        clear4();
        mem4[0] = 8'h31; mem4[1] = 8'h56; mem4[2] = 8'h48; mem4[4] = 8'h3B;
        reset4();
        tick(4);
        check("sub_acc", dout4, 14);
        tick(4);
        check("brn_pc", addr4, 7);

        // LDA 6, STA 9, BRZ 5 (not taken)
        clear4();
        mem4[0] = 8'h61; mem4[1] = 8'h93; mem4[2] = 8'h59;
        reset4();
        nwe = 0;
        for (int c = 0; c < 6; c++) begin
            tick(1);
            if (we4) begin
                nwe++;
                check("sta_addr", addr4, 9);
                check("sta_data", dout4, 6);
            end
        end
        check("sta_we_cycles", nwe, 1);
        check("sta_mem", mem4[9], 8'h60);
        check("brz_nt_pc", addr4, 3);

        // W=8: JMP 0xFF, NOP at 0xFF wraps to 0
        mem8[0] = 12'hFF8; mem8[255] = 12'h000;
        reset8();
        tick(2);
        check("w8_jmp_pc", addr8, 8'hFF);
        tick(2);
        check("w8_wrap_pc", addr8, 0);
        // W=8: LDA ind 0x20 (operand 0x80), BRN 0x10 at pc=1
        mem8[0] = 12'h202; mem8[1] = 12'h10B; mem8[32] = 12'h800;
        reset8();
        tick(2);
        check("w8_ldai_acc", dout8, 8'h80);
        tick(2);
        check("w8_brn_pc", addr8, 8'h11);

`ifdef ACC_CPU_SCAN_EN
        // Freeze mid-EXEC of ADD 0xC with acc=5, pc=1
        clear4();
        mem4[0] = 8'h51; mem4[1] = 8'hC4; mem4[2] = 8'h0F;
        reset4();
        tick(3);
        snap = {4'h4, 4'hC, 4'h5, 3'b000, 4'h1, 2'b01};
        scan_en = 1'b1;
        for (int i = 0; i < 21; i++) begin
            tick(1);
            check($sformatf("scan_bit%0d", i), scan_out4, snap[20-i]);
        end
        tick(1);
        check("scan_past_end", scan_out4, 0);
        check("scan_frozen_acc", dout4, 5);
        check("scan_we", we4, 0);
        scan_en = 1'b0;
        tick(1);
        check("scan_resume_acc", dout4, 1);
        tick(2);
        check("scan_resume_halt", halted4, 1);
        scan_en = 1'b1;
        tick(2);
        rst4 = 1'b1;
        tick(1);
        rst4 = 1'b0;
        check("scan_rst_out", scan_out4, 0);
        check("scan_rst_halted", halted4, 0);
        check("scan_rst_acc", dout4, 0);
        scan_en = 1'b0;
`endif

        // Random programs against the reference model
        for (int p = 0; p < 150; p++) begin
            for (int k = 0; k < 16; k++) begin
                int op;
                op = $urandom_range(0, 15);
                if (op == 15 && $urandom_range(0, 3) != 0) op = 0;
                mm[k]   = $urandom_range(0, 15) * 16 + op;
                mem4[k] = 8'(mm[k]);
            end
            m_pc = 0; m_acc = 0; m_c = 0; m_z = 0; m_n = 0; m_halt = 0;
            reset4();
            for (int s = 0; s < 20; s++) begin
                model_step(ew);
                tick(1);
                check("rnd_we", we4, ew);
                tick(1);
                check("rnd_pc", addr4, m_pc);
                check("rnd_acc", dout4, m_acc);
                check("rnd_halted", halted4, m_halt);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
